flipper_angle_ctrl: RTL and testbench

Per-flipper motion controller that turns a raw board flipper button into the flipper's current pose. It sits directly upstream of the flipper renderer in the pinball top level. Each frame it advances the flipper angle at the frame strobe and presents two values: the angle, and the tangent magnitude of its offset from horizontal. The renderer uses these to draw the flipper wedge, and the ball logic uses them for collisions. One instance is built per flipper (left, right).

---
 rtl/flipper_angle_ctrl.sv | 144 ++++++++++++++
 tb/tb_flipper_angle_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flipper_angle_ctrl.sv
// Per-flipper pose controller: button -> angle FSM stepped once per frame, plus tan(|angle-45|) lookup.
// Optional FLIPPER_DEBOUNCE_EN: press must be seen on 2 consecutive frame ticks to change state.
module flipper_angle_ctrl #(
  parameter int unsigned REST_ANGLE = 15,
  parameter int unsigned MAX_ANGLE  = 75,
  parameter int unsigned UP_STEP    = 10,
  parameter int unsigned DOWN_STEP  = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic        flipperbutton,
  output logic [31:0] angle,
  output logic [31:0] tantetavar,
  output logic        o_kick
);

  typedef enum logic [1:0] {S_REST, S_RISING, S_HELD, S_FALLING} state_t;

  localparam logic [7:0] LP_REST = 8'(REST_ANGLE);
  localparam logic [7:0] LP_MAX  = 8'(MAX_ANGLE);
  localparam logic [7:0] LP_UP   = 8'(UP_STEP);
  localparam logic [7:0] LP_DOWN = 8'(DOWN_STEP);
  localparam logic [7:0] LP_HORZ = 8'd45;

  logic [1:0]  r_sync;
  logic        w_press_s;
  logic        w_tick;
  logic        w_pr;
  state_t      r_state;
  logic [7:0]  r_angle;
  logic        r_kick;
  logic        r_tick_d;
  logic [31:0] r_tan;
  logic [8:0]  w_up_sum;
  logic [7:0]  w_up_angle;
  logic [8:0]  w_dn_floor;
  logic [7:0]  w_dn_angle;
  logic [7:0]  w_off;
  logic [31:0] w_tan;

  assign w_tick    = i_animate & i_ani_stb;
  assign w_press_s = ~r_sync[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '1;
    else       r_sync <= {r_sync[0], flipperbutton};
  end

`ifdef FLIPPER_DEBOUNCE_EN
  logic r_last;
  logic r_pr;

  // The current tick's sample combines with the previous one, so pr changes on the second agreeing tick.
  always_comb begin
    w_pr = r_pr;
    if (w_press_s && r_last)        w_pr = 1'b1;
    else if (!w_press_s && !r_last) w_pr = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b0;
      r_pr   <= 1'b0;
    end else if (w_tick) begin
      r_last <= w_press_s;
      r_pr   <= w_pr;
    end
  end
`else
  assign w_pr = w_press_s;
`endif

  assign w_up_sum   = {1'b0, r_angle} + {1'b0, LP_UP};
  assign w_up_angle = (w_up_sum >= {1'b0, LP_MAX}) ? LP_MAX : w_up_sum[7:0];
  assign w_dn_floor = {1'b0, LP_REST} + {1'b0, LP_DOWN};
  assign w_dn_angle = ({1'b0, r_angle} <= w_dn_floor) ? LP_REST : r_angle - LP_DOWN;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_REST;
      r_angle <= LP_REST;
      r_kick  <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        S_REST: begin
          if (w_pr) begin
            r_angle <= w_up_angle;
            r_state <= (w_up_angle == LP_MAX) ? S_HELD : S_RISING;
            r_kick  <= (w_up_angle != LP_MAX);
          end
        end
        S_HELD: begin
          if (!w_pr) begin
            r_angle <= w_dn_angle;
            r_state <= (w_dn_angle == LP_REST) ? S_REST : S_FALLING;
            r_kick  <= 1'b0;
          end
        end
        default: begin
          // RISING and FALLING both pick the step of whichever way pr points now.
          if (w_pr) begin
            r_angle <= w_up_angle;
            r_state <= (w_up_angle == LP_MAX) ? S_HELD : S_RISING;
            r_kick  <= (w_up_angle != LP_MAX);
          end else begin
            r_angle <= w_dn_angle;
            r_state <= (w_dn_angle == LP_REST) ? S_REST : S_FALLING;
            r_kick  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign w_off = (r_angle >= LP_HORZ) ? r_angle - LP_HORZ : LP_HORZ - r_angle;

  always_comb begin
    w_tan = 32'd5773503;
    if      (w_off < 8'd5)  w_tan = 32'd0;
    else if (w_off < 8'd10) w_tan = 32'd874887;
    else if (w_off < 8'd15) w_tan = 32'd1763270;
    else if (w_off < 8'd20) w_tan = 32'd2679492;
    else if (w_off < 8'd25) w_tan = 32'd3639702;
    else if (w_off < 8'd30) w_tan = 32'd4663077;
  end

  // Tangent refreshes only the cycle after a tick, so the reset value holds until the first frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tick_d <= 1'b0;
      r_tan    <= 32'd2679492;
    end else begin
      r_tick_d <= w_tick;
      if (r_tick_d) r_tan <= w_tan;
    end
  end

  assign angle      = {24'd0, r_angle};
  assign tantetavar = r_tan;
  assign o_kick     = r_kick;

endmodule

// File: tb/tb_flipper_angle_ctrl.sv
// Bench for flipper_angle_ctrl: frame-level reference model checked every cycle plus literal pose checks.
module tb_flipper_angle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        anim;
  logic        btn;
  logic [31:0] angle;
  logic [31:0] tan_o;
  logic        kick;

  always #5 clk = ~clk;

  flipper_angle_ctrl #(
    .REST_ANGLE(15),
    .MAX_ANGLE (75),
    .UP_STEP   (10),
    .DOWN_STEP (5)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ani_stb    (stb),
    .i_animate    (anim),
    .flipperbutton(btn),
    .angle        (angle),
    .tantetavar   (tan_o),
    .o_kick       (kick)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Reference: motion direction 0 rest, 1 up, 2 held at top, 3 down.
  int          m_angle;
  int          m_dir;
  bit          m_kick;
  logic [31:0] m_tan;
  bit          m_tan_due;
  bit          m_last;
  bit          m_pr;

  function automatic logic [31:0] tan_of(input int a);
    int off;
    int idx;
    off = (a >= 45) ? a - 45 : 45 - a;
    idx = off / 5;
    if (idx > 6) idx = 6;
    case (idx)
      0: return 32'd0;
      1: return 32'd874887;
      2: return 32'd1763270;
      3: return 32'd2679492;
      4: return 32'd3639702;
      5: return 32'd4663077;
      default: return 32'd5773503;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_angle = 15; m_dir = 0; m_kick = 0; m_tan = 32'd2679492;
        m_tan_due = 0; m_last = 0; m_pr = 0;
      end else begin
        bit p;
        bit pr;
        if (m_tan_due) m_tan = tan_of(m_angle);
        m_tan_due = 0;
        if (stb && anim) begin
          p = !btn;
`ifdef FLIPPER_DEBOUNCE_EN
          if (p && m_last) m_pr = 1;
          else if (!p && !m_last) m_pr = 0;
          m_last = p;
          pr = m_pr;
`else
          pr = p;
`endif
          if (pr && m_dir != 2) begin
            m_angle = (m_angle + 10 > 75) ? 75 : m_angle + 10;
            m_dir   = (m_angle == 75) ? 2 : 1;
          end else if (!pr && m_dir != 0) begin
            m_angle = (m_angle - 5 < 15) ? 15 : m_angle - 5;
            m_dir   = (m_angle == 15) ? 0 : 3;
          end
          m_kick = (m_dir == 1);
          m_tan_due = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("angle", angle, 32'(m_angle));
        chk("kick", {31'd0, kick}, {31'd0, m_kick});
        chk("tantetavar", tan_o, m_tan);
      end
    end
  end

  // Button changes settle through the synchronizer before the tick edge.
  task automatic tick();
    repeat (3) @(posedge clk);
    #2 anim = 1'b1;
    @(posedge clk);
    #2 anim = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic to_rest();
    btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (m_angle == 15 && m_dir == 0) break;
      tick();
    end
    chk("return_to_rest", angle, 32'd15);
  endtask

  int raise_exp[6] = '{25, 35, 45, 55, 65, 75};

  initial begin
    rst = 1'b1; stb = 1'b1; anim = 1'b0; btn = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk_en = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_angle", angle, 32'd15);
    chk("reset_tan", tan_o, 32'd2679492);
    chk("reset_kick", {31'd0, kick}, 32'd0);

    // Frame pulse without the pixel strobe is not a tick.
    btn = 1'b0;
    repeat (3) @(posedge clk);
    #2 stb = 1'b0; anim = 1'b1;
    @(posedge clk);
    #2 anim = 1'b0; stb = 1'b1;
    repeat (2) @(posedge clk);
    #2 chk("no_tick_angle", angle, 32'd15);

    for (int i = 0; i < 6; i++) begin
      tick();
`ifndef FLIPPER_DEBOUNCE_EN
      chk("raise_angle", angle, 32'(raise_exp[i]));
      if (i == 2) chk("tan_at_45", tan_o, 32'd0);
      if (i == 4) chk("kick_rising", {31'd0, kick}, 32'd1);
`endif
    end
    tick();
`ifndef FLIPPER_DEBOUNCE_EN
    chk("held_angle", angle, 32'd75);
    chk("tan_at_75", tan_o, 32'd5773503);
    chk("kick_held", {31'd0, kick}, 32'd0);
`endif

    btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
`ifndef FLIPPER_DEBOUNCE_EN
      chk("fall_angle", angle, 32'(75 - 5 * i));
`endif
    end
    tick();
    to_rest();

    // Press and release entirely between ticks.
    btn = 1'b0;
    repeat (2) @(posedge clk);
    #2 btn = 1'b1;
    tick();
    chk("glitch_between_ticks", angle, 32'd15);

    // Reversal.
    btn = 1'b0;
    tick();
    tick();
`ifndef FLIPPER_DEBOUNCE_EN
    chk("rev_up", angle, 32'd35);
`endif
    btn = 1'b1;
    tick();
`ifndef FLIPPER_DEBOUNCE_EN
    chk("rev_down", angle, 32'd30);
    chk("rev_down_kick", {31'd0, kick}, 32'd0);
`endif
    btn = 1'b0;
    tick();
`ifndef FLIPPER_DEBOUNCE_EN
    chk("rev_up_again", angle, 32'd40);
    chk("rev_up_kick", {31'd0, kick}, 32'd1);
`endif
    to_rest();

`ifdef FLIPPER_DEBOUNCE_EN
    btn = 1'b0;
    tick();
    btn = 1'b1;
    tick();
    tick();
    chk("db_glitch", angle, 32'd15);
    btn = 1'b0;
    tick();
    chk("db_first", angle, 32'd15);
    tick();
    chk("db_second", angle, 32'd25);
    to_rest();
`endif

    // Mid-motion reset with the button still held.
    btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_angle == 55) break;
      tick();
    end
    chk("reach_55", angle, 32'd55);
    chk("reach_55_kick", {31'd0, kick}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2;
    chk("midreset_angle", angle, 32'd15);
    chk("midreset_tan", tan_o, 32'd2679492);
    chk("midreset_kick", {31'd0, kick}, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    to_rest();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
